// File: rtl/theia_omem_drain.sv
// Output-memory drain: walks every core's output bank through the OMBSEL/OMADR read port
// and streams the returned words over valid/ready, buffered by a 2-entry FIFO.
module theia_omem_drain #(
    parameter int WB_WIDTH  = 32,
    parameter int CORE_BITS = 4,
    parameter int NUM_CORES = 16
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 START_I,
    input  logic [WB_WIDTH-1:0]  WORDS_I,
    output logic [CORE_BITS-1:0] OMBSEL_O,
    output logic [WB_WIDTH-1:0]  OMADR_O,
    input  logic [WB_WIDTH-1:0]  OMEM_I,
    output logic [WB_WIDTH-1:0]  DAT_O,
    output logic [CORE_BITS-1:0] BANK_O,
    output logic                 VLD_O,
    input  logic                 RDY_I,
    output logic                 LAST_O,
    output logic                 BUSY_O,
    output logic                 DONE_O
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WB_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [CORE_BITS-1:0] bsel_q, bsel_d;
    logic [WB_WIDTH-1:0]  adr_q, adr_d;
    logic                 zdone_q, zdone_d;

    // One read in flight; its bank/last tags travel with it to the capture cycle.
    logic                 infl_q;
    logic [CORE_BITS-1:0] infl_bank_q;
    logic                 infl_last_q;

    logic [1:0][WB_WIDTH-1:0]  fdat_q;
    logic [1:0][CORE_BITS-1:0] fbank_q;
    logic [1:0]                flast_q;
    logic                      wr_q, rd_q;
    logic [1:0]                cnt_q;

    logic pop, push, issue, last_adr, last_bank, flush_done;

    assign pop        = (cnt_q != 2'd0) && RDY_I;
    assign push       = infl_q;
    assign last_adr   = (adr_q == wcnt_q - WB_WIDTH'(1));
    assign last_bank  = (bsel_q == CORE_BITS'(NUM_CORES - 1));
    // Count the slot freed by this cycle's pop so the stream sustains one beat per cycle.
    assign issue      = (state_q == S_RUN) &&
                        (({1'b0, cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));
    assign flush_done = (state_q == S_FLUSH) && (cnt_q == 2'd0) && !infl_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        bsel_d  = bsel_q;
        adr_d   = adr_q;
        zdone_d = 1'b0;
        case (state_q)
            S_IDLE: if (START_I) begin
                wcnt_d = WORDS_I;
                bsel_d = '0;
                adr_d  = '0;
                if (WORDS_I != '0) state_d = S_RUN;
                else               zdone_d = 1'b1;
            end
            S_RUN: if (issue) begin
                if (last_adr) begin
                    adr_d  = '0;
                    bsel_d = bsel_q + CORE_BITS'(1);
                    if (last_bank) state_d = S_FLUSH;
                end else begin
                    adr_d = adr_q + WB_WIDTH'(1);
                end
            end
            S_FLUSH: if (flush_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            bsel_q      <= '0;
            adr_q       <= '0;
            zdone_q     <= 1'b0;
            infl_q      <= 1'b0;
            infl_bank_q <= '0;
            infl_last_q <= 1'b0;
            fdat_q      <= '0;
            fbank_q     <= '0;
            flast_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            bsel_q      <= bsel_d;
            adr_q       <= adr_d;
            zdone_q     <= zdone_d;
            infl_q      <= issue;
            infl_bank_q <= bsel_q;
            infl_last_q <= last_adr && last_bank;
            if (push) begin
                fdat_q[wr_q]  <= OMEM_I;
                fbank_q[wr_q] <= infl_bank_q;
                flast_q[wr_q] <= infl_last_q;
                wr_q          <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign OMBSEL_O = bsel_q;
    assign OMADR_O  = adr_q;
    assign VLD_O    = (cnt_q != 2'd0);
    assign DAT_O    = fdat_q[rd_q];
    assign BANK_O   = fbank_q[rd_q];
    assign LAST_O   = flast_q[rd_q] && VLD_O;
    assign BUSY_O   = (state_q != S_IDLE);
    assign DONE_O   = zdone_q || flush_done;

endmodule

// File: tb/tb_theia_omem_drain.sv
// Bench for theia_omem_drain: synchronous RAM model, queue-based expected stream,
// per-cycle checks of beats, handshake hold, DONE/BUSY and outstanding reads.
module tb_theia_omem_drain;
    localparam int W  = 32;
    localparam int CB = 4;
    localparam int NC = 16;

    logic          CLK_I = 1'b0;
    logic          RST_I, START_I, RDY_I;
    logic [W-1:0]  WORDS_I, OMEM_I;
    logic [CB-1:0] OMBSEL_O, BANK_O;
    logic [W-1:0]  OMADR_O, DAT_O;
    logic          VLD_O, LAST_O, BUSY_O, DONE_O;

    always #5 CLK_I = ~CLK_I;

    theia_omem_drain #(.WB_WIDTH(W), .CORE_BITS(CB), .NUM_CORES(NC)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .WORDS_I(WORDS_I),
        .OMBSEL_O(OMBSEL_O), .OMADR_O(OMADR_O), .OMEM_I(OMEM_I),
        .DAT_O(DAT_O), .BANK_O(BANK_O), .VLD_O(VLD_O), .RDY_I(RDY_I),
        .LAST_O(LAST_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O)
    );

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CB-1:0] b;
        logic          l;
    } beat_t;

    logic [15:0] salt;
    function automatic logic [W-1:0] memval(input logic [CB-1:0] b, input logic [W-1:0] a);
        return {b, a[11:0], salt};
    endfunction

    always @(posedge CLK_I) OMEM_I <= memval(OMBSEL_O, OMADR_O);

    int errors = 0, checks = 0;
    int cyc = 0;
    int mode = 0;  // 0: ready high, 1: toggle, 2: random, 3: ready low
    always @(posedge CLK_I) cyc++;
    always @(posedge CLK_I) begin
        #1;
        case (mode)
            0: RDY_I = 1'b1;
            1: RDY_I = ~RDY_I;
            2: RDY_I = 1'($urandom_range(0, 1));
            default: RDY_I = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    beat_t q[$];
    beat_t e, hold_v;
    bit    busy_exp = 0, done_pending = 0, done_seen = 0, hold_prev = 0, got_first = 0;
    int    issued = 0, xfer = 0, nbeats = 0, first_cyc = 0, start_cyc = 0;
    logic [W-1:0]    first_dat, last_dat;
    logic [CB+W-1:0] prev_addr = '0;

    always @(negedge CLK_I) begin
        if (!RST_I) begin
            chk("done", 64'(DONE_O), 64'(done_pending));
            chk("busy", 64'(BUSY_O), 64'(busy_exp));
            if (done_pending) begin
                done_seen = 1;
                busy_exp  = 0;
            end
            done_pending = 0;
            if ({OMBSEL_O, OMADR_O} != prev_addr) issued++;
            prev_addr = {OMBSEL_O, OMADR_O};
            chk("outstanding_le2", 64'((issued - xfer) <= 2), 64'd1);
            if (hold_prev) begin
                chk("hold_vld", 64'(VLD_O), 64'd1);
                chk("hold_beat", 64'({DAT_O, BANK_O, LAST_O}), 64'(hold_v));
            end
            if (mode == 0 && got_first && q.size() > 0) chk("stream_gapless", 64'(VLD_O), 64'd1);
            if (VLD_O && !got_first) begin
                got_first = 1;
                first_cyc = cyc;
            end
            if (VLD_O && RDY_I) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got bank %0d data %0h, expected no beat", BANK_O, DAT_O);
                end else begin
                    e = q.pop_front();
                    chk("beat", 64'({DAT_O, BANK_O, LAST_O}), 64'(e));
                    xfer++;
                    nbeats++;
                    if (nbeats == 1) first_dat = DAT_O;
                    last_dat = DAT_O;
                    if (e.l) done_pending = 1;
                end
            end
            hold_prev = VLD_O && !RDY_I;
            hold_v    = {DAT_O, BANK_O, LAST_O};
        end
    end

    task automatic start_drain(input int words, input int m, input logic [15:0] s);
        beat_t x;
        mode = m;
        @(posedge CLK_I);
        #1;
        salt = s;
        q.delete();
        for (int b = 0; b < NC; b++)
            for (int a = 0; a < words; a++) begin
                x.d = memval(CB'(b), W'(a));
                x.b = CB'(b);
                x.l = (b == NC - 1) && (a == words - 1);
                q.push_back(x);
            end
        got_first = 0; nbeats = 0; issued = 0; xfer = 0; done_seen = 0;
        prev_addr = {OMBSEL_O, OMADR_O};
        WORDS_I = W'(words);
        START_I = 1'b1;
        @(posedge CLK_I);
        #1;
        start_cyc = cyc;
        START_I  = 1'b0;
        WORDS_I  = $urandom;
        busy_exp = (words != 0);
        if (words == 0) done_pending = 1;
    endtask

    task automatic finish_drain();
        for (int i = 0; i < 3000 && !done_seen; i++) @(posedge CLK_I);
        chk("drain_completes", 64'(done_seen), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);
        repeat (2) @(posedge CLK_I);
    endtask

    initial begin
        RST_I = 1'b1; START_I = 1'b0; WORDS_I = '0; RDY_I = 1'b1; salt = '0;
        repeat (2) @(posedge CLK_I);
        #1;
        chk("rst_vld", 64'(VLD_O), 64'd0);
        chk("rst_busy", 64'(BUSY_O), 64'd0);
        chk("rst_addr", 64'({OMBSEL_O, OMADR_O}), 64'd0);
        RST_I = 1'b0;
        repeat (2) @(posedge CLK_I);

        // 4 words, ready high: gapless 64-beat stream
        start_drain(4, 0, 16'h0000);
        finish_drain();
        chk("t1_beats", 64'(nbeats), 64'd64);
        chk("t1_latency", 64'(first_cyc - start_cyc), 64'd2);
        chk("t1_first", 64'(first_dat), 64'h0000_0000);
        chk("t1_last", 64'(last_dat), 64'hF003_0000);

        // 3 words, ready toggling
        start_drain(3, 1, 16'(($urandom)));
        finish_drain();
        chk("t2_beats", 64'(nbeats), 64'd48);

        // 2 words, ready low for 10 cycles then released
        start_drain(2, 3, 16'h5a5a);
        repeat (10) @(posedge CLK_I);
        chk("t3_reads_issued", 64'(issued), 64'd2);
        chk("t3_head_vld", 64'(VLD_O), 64'd1);
        chk("t3_head_beat", 64'({DAT_O, BANK_O}), 64'({memval(4'd0, 32'd0), 4'd0}));
        mode = 0;
        finish_drain();
        chk("t3_beats", 64'(nbeats), 64'd32);

        // zero words: DONE only
        start_drain(0, 0, 16'h1111);
        finish_drain();
        chk("t4_beats", 64'(nbeats), 64'd0);

        // async reset in bank 5
        start_drain(4, 0, 16'h2222);
        for (int i = 0; i < 500 && OMBSEL_O != 4'd5; i++) @(negedge CLK_I);
        chk("t5_reached_bank5", 64'(OMBSEL_O), 64'd5);
        #2;
        RST_I = 1'b1;
        #1;
        chk("t5_rst_outs", 64'({VLD_O, LAST_O, BUSY_O, DONE_O}), 64'd0);
        chk("t5_rst_data", 64'({DAT_O, BANK_O}), 64'd0);
        chk("t5_rst_addr", 64'({OMBSEL_O, OMADR_O}), 64'd0);
        q.delete(); busy_exp = 0; done_pending = 0; hold_prev = 0;
        @(posedge CLK_I);
        #3;
        RST_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        start_drain(1, 0, 16'h3333);
        finish_drain();
        chk("t5_beats", 64'(nbeats), 64'd16);

        // START re-pulsed during RUN with another word count is ignored
        start_drain(5, 2, 16'(($urandom)));
        repeat (5) @(posedge CLK_I);
        #1;
        WORDS_I = 32'd9;
        START_I = 1'b1;
        @(posedge CLK_I);
        #1;
        START_I = 1'b0;
        finish_drain();
        chk("t6_beats", 64'(nbeats), 64'd80);

        // randomized drains
        for (int k = 0; k < 4; k++) begin
            int w;
            w = int'($urandom_range(1, 6));
            start_drain(w, 2, 16'(($urandom)));
            finish_drain();
            chk("rand_beats", 64'(nbeats), 64'(NC * w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/theia_omem_drain.md
Name: theia_omem_drain

Overview:
Downstream readout stage for the per-core output memories of the THEIA top level. After a frame completes, it walks every core's output bank through the top-level OMBSEL/OMADR read port and captures the returned words. It then streams them to the host/display side over a valid/ready interface, tagged with bank and last-beat markers. It absorbs the one-cycle memory read latency and consumer backpressure with a 2-entry output FIFO.

Parameters:
WB_WIDTH, 32, data and address width; matches the output-memory read port.
CORE_BITS, 4, width of the bank select.
NUM_CORES, 16, number of banks drained, indices 0..NUM_CORES-1.

Ports:
CLK_I  in  1  clock; all state is updated on the rising edge.
RST_I  in  1  reset, asynchronous, active-high.
START_I  in  1  begin a drain; sampled only in IDLE.
WORDS_I  in  WB_WIDTH  words per bank to read; latched on accepted START_I.
OMBSEL_O  out  CORE_BITS  bank select to the output-memory mux.
OMADR_O  out  WB_WIDTH  read address within the bank.
OMEM_I  in  WB_WIDTH  read data; valid one cycle after OMBSEL_O/OMADR_O (synchronous RAM).
DAT_O  out  WB_WIDTH  stream data (FIFO head).
BANK_O  out  CORE_BITS  bank index of the DAT_O word.
VLD_O  out  1  DAT_O/BANK_O/LAST_O valid.
RDY_I  in  1  consumer ready; a beat transfers when VLD_O & RDY_I.
LAST_O  out  1  final beat of the whole drain.
BUSY_O  out  1  high in RUN and FLUSH.
DONE_O  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (async assert, any state): state IDLE; OMBSEL_O=0; OMADR_O=0; FIFO empty; inflight=0.
  - Outputs under reset: VLD_O=0, LAST_O=0, BUSY_O=0, DONE_O=0, DAT_O=0, BANK_O=0.
  - Reset mid-drain abandons the drain; no DONE_O pulse; words already in the FIFO are discarded.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - On START_I=1: latch WORDS_I into wcnt; clear the bank/address counters.
  - If WORDS_I!=0, go to RUN; if WORDS_I==0, pulse DONE_O next cycle and stay in IDLE (no beats).
- RUN issue rule:
  - Internal issue = RUN & ((fifo_count + inflight - pop) < 2), where pop = VLD_O & RDY_I.
  - On issue: inflight<=1 next cycle, and the address advances.
  - Address advance: OMADR_O+1; if OMADR_O==wcnt-1, then OMADR_O<=0 and OMBSEL_O+1.
  - When the final address (bank NUM_CORES-1, address wcnt-1) issues, go to FLUSH.
- Capture: the cycle after an issue, push {OMEM_I, bank of that issue, last flag} into the FIFO.
  - The last flag is set only for the final address of the final bank.
  - The bank and last tags are pipelined alongside inflight.
- FIFO: 2 entries; simultaneous push and pop in the same cycle is legal and keeps the count.
  - Overflow is impossible by the issue rule; the bench asserts that push never happens when full without a pop.
- FLUSH: no issues; when the FIFO is empty and inflight=0, pulse DONE_O for one cycle and go to IDLE.
  - DONE_O asserts the cycle after the LAST_O beat transfers.
- Throughput and latency:
  - With RDY_I held at 1, the stream sustains one beat per cycle.
  - The first VLD_O rises 2 cycles after the START_I edge (RUN issue at +1, capture at +2).
- Handshake stability: while VLD_O=1 and RDY_I=0, DAT_O, BANK_O and LAST_O hold stable and VLD_O stays high.
- START_I while BUSY_O=1 is ignored; WORDS_I changes after the latch have no effect.
- Width rule: OMBSEL_O wraps modulo 2^CORE_BITS, but RUN ends before the wrap when NUM_CORES=2^CORE_BITS.
  - A wcnt of 2^WB_WIDTH-1 is legal.
- Total beats per drain = NUM_CORES*wcnt, ordered bank-major, address-minor.

Test Plan:
- WORDS_I=4, RDY_I=1, bank b address a preloaded with value {b,a} -> 64 beats in order (0,0)..(15,3), one per cycle, starting at cycle +2; LAST_O on beat 64 only; DONE_O one cycle later.
- WORDS_I=3, RDY_I toggling 1/0 every cycle -> 48 beats; no duplicates or drops; data held stable during RDY_I=0; FIFO never exceeds 2 entries.
- WORDS_I=2, RDY_I=0 for 10 cycles after START_I -> exactly 2 reads issued; VLD_O=1 with beat (0,0) held; on release, all 32 beats delivered.
- WORDS_I=0 -> no VLD_O; DONE_O pulses the cycle after START_I; BUSY_O stays 0.
- RST_I asserted asynchronously mid-RUN (bank 5) -> all outputs 0 immediately, no DONE_O; a new START_I with WORDS_I=1 then drains cleanly from bank 0, producing 16 beats.
- START_I pulsed again during RUN with a different WORDS_I -> ignored; beat count matches the original WORDS_I.
